// File: rtl/color_match_checker.sv
// Colour FIFO fed by the randomizer; scores button presses against the head.
// Tracks score/lives and ends the game when lives run out.
module color_match_checker #(
   parameter int DEPTH      = 8,
   parameter int NUM_COLORS = 6,
   parameter int SCORE_W    = 8,
   parameter int MAX_LIVES  = 3
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [2:0]                     color_in,
   input  logic                           color_valid,
   output logic                           color_ready,
   input  logic                           press_valid,
   input  logic [2:0]                     press_color,
   output logic                           hit,
   output logic                           miss,
   output logic [SCORE_W-1:0]             score,
   output logic [$clog2(MAX_LIVES+1)-1:0] lives,
   output logic [$clog2(DEPTH+1)-1:0]     pending,
   output logic                           overflow,
   output logic                           game_over
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = $clog2(DEPTH+1);
   localparam int LW = $clog2(MAX_LIVES+1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         mem_q [DEPTH];
   logic [AW-1:0]      rd_q, rd_d;
   logic [AW-1:0]      wr_q, wr_d;
   logic [PW-1:0]      cnt_q, cnt_d;
   logic [SCORE_W-1:0] score_q, score_d;
   logic [LW-1:0]      lives_q, lives_d;
   logic               hit_q, hit_d;
   logic               miss_q, miss_d;
   logic               ovf_q, ovf_d;

   logic in_play, full, empty, legal;
   logic push, pop, press, match, lose;

   assign in_play     = (state_q == PLAY);
   assign full        = (cnt_q == PW'(DEPTH));
   assign empty       = (cnt_q == '0);
   assign color_ready = in_play && !full;
   assign legal       = ({1'b0, color_in} < 4'(NUM_COLORS));
   // Illegal codes are handshaken but never written.
   assign push        = color_valid && color_ready && legal;
   assign press       = in_play && press_valid;
   assign pop         = press && !empty;
   assign match       = pop && (mem_q[rd_q] == press_color);
   assign lose        = press && !match;

   always_comb begin
      state_d = state_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      score_d = score_q;
      lives_d = lives_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE, OVER: begin
            if (start) begin
               state_d = PLAY;
               rd_d    = '0;
               wr_d    = '0;
               cnt_d   = '0;
               score_d = '0;
               lives_d = LW'(MAX_LIVES);
               ovf_d   = 1'b0;
            end
         end
         PLAY: begin
            if (push) wr_d = wr_q + AW'(1);
            if (pop)  rd_d = rd_q + AW'(1);
            case ({push, pop})
               2'b10:   cnt_d = cnt_q + PW'(1);
               2'b01:   cnt_d = cnt_q - PW'(1);
               default: cnt_d = cnt_q;
            endcase
            if (color_valid && full) ovf_d = 1'b1;
            if (match) begin
               hit_d = 1'b1;
               if (score_q != '1) score_d = score_q + SCORE_W'(1);
            end
            if (lose) begin
               miss_d  = 1'b1;
               lives_d = lives_q - LW'(1);
               if (lives_q == LW'(1)) state_d = OVER;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         rd_q    <= '0;
         wr_q    <= '0;
         cnt_q   <= '0;
         score_q <= '0;
         lives_q <= LW'(MAX_LIVES);
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         cnt_q   <= cnt_d;
         score_q <= score_d;
         lives_q <= lives_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= color_in;
   end

   assign hit       = hit_q;
   assign miss      = miss_q;
   assign score     = score_q;
   assign lives     = lives_q;
   assign pending   = cnt_q;
   assign overflow  = ovf_q;
   assign game_over = (state_q == OVER);

endmodule

// File: tb/tb_color_match_checker.sv
// Directed bench for color_match_checker; a second instance with a
// 2-bit score shares the stimulus to exercise saturation.
module tb_color_match_checker;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       start = 1'b0;
   logic [2:0] color_in = '0;
   logic       color_valid = 1'b0;
   logic       press_valid = 1'b0;
   logic [2:0] press_color = '0;

   logic       color_ready, hit, miss, overflow, game_over;
   logic [7:0] score;
   logic [1:0] lives;
   logic [3:0] pending;

   logic       s_ready, s_hit, s_miss, s_ovf, s_go;
   logic [1:0] s_score;
   logic [1:0] s_lives;
   logic [3:0] s_pending;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   color_match_checker u_dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .color_in(color_in), .color_valid(color_valid),
      .color_ready(color_ready), .press_valid(press_valid),
      .press_color(press_color), .hit(hit), .miss(miss),
      .score(score), .lives(lives), .pending(pending),
      .overflow(overflow), .game_over(game_over)
   );

   color_match_checker #(.SCORE_W(2)) u_sat (
      .clk(clk), .reset_n(reset_n), .start(start),
      .color_in(color_in), .color_valid(color_valid),
      .color_ready(s_ready), .press_valid(press_valid),
      .press_color(press_color), .hit(s_hit), .miss(s_miss),
      .score(s_score), .lives(s_lives), .pending(s_pending),
      .overflow(s_ovf), .game_over(s_go)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] c);
      color_valid = 1'b1;
      color_in    = c;
      step();
      color_valid = 1'b0;
   endtask

   task automatic press(input logic [2:0] c);
      press_valid = 1'b1;
      press_color = c;
      step();
      press_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      #2;
      chk("rst_score", score, 0);
      chk("rst_lives", lives, 3);
      chk("rst_pending", pending, 0);
      chk("rst_flags", {hit, miss, overflow, game_over}, 0);
      chk("rst_ready", color_ready, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // IDLE: pushes and presses ignored
      push(3'd1);
      chk("idle_pending", pending, 0);
      chk("idle_ovf", overflow, 0);
      press(3'd1);
      chk("idle_miss", miss, 0);
      chk("idle_lives", lives, 3);

      do_start();
      chk("play_ready", color_ready, 1);

      // Test 1
      push(3'd2); push(3'd5); push(3'd0);
      chk("t1_pend3", pending, 3);
      press(3'd2);
      chk("t1_hit1", hit, 1);
      chk("t1_score1", score, 1);
      press(3'd5);
      chk("t1_hit2", hit, 1);
      press(3'd0);
      chk("t1_hit3", hit, 1);
      chk("t1_score", score, 3);
      chk("t1_pend0", pending, 0);
      chk("t1_lives", lives, 3);
      step();
      chk("t1_hit_pulse", hit, 0);

      // Test 2
      push(3'd4);
      press(3'd1);
      chk("t2_miss", miss, 1);
      chk("t2_hit", hit, 0);
      chk("t2_lives2", lives, 2);
      chk("t2_pend0", pending, 0);
      press(3'd3);
      chk("t2_empty_miss", miss, 1);
      chk("t2_lives1", lives, 1);
      chk("t2_go_early", game_over, 0);
      press(3'd3);
      chk("t2_lives0", lives, 0);
      chk("t2_go", game_over, 1);
      chk("t2_ready", color_ready, 0);
      press(3'd3);
      chk("t2_over_miss", miss, 0);
      chk("t2_over_score", score, 3);

      // Restart from OVER
      do_start();
      chk("rs_go", game_over, 0);
      chk("rs_score", score, 0);
      chk("rs_lives", lives, 3);
      chk("rs_pend", pending, 0);

      // Test 3
      for (int i = 0; i < 8; i++) push(3'(i % 6));
      chk("t3_pend8", pending, 8);
      chk("t3_ready0", color_ready, 0);
      chk("t3_ovf_pre", overflow, 0);
      push(3'd2);
      chk("t3_ovf", overflow, 1);
      chk("t3_pend_ovf", pending, 8);
      press(3'd0);
      chk("t3_hit", hit, 1);
      chk("t3_pend7", pending, 7);
      chk("t3_ready1", color_ready, 1);
      chk("t3_ovf_sticky", overflow, 1);
      push(3'd2);
      chk("t3_refill", pending, 8);
      // Full at cycle start: push refused even though a pop happens
      color_valid = 1'b1; color_in = 3'd3;
      press(3'd1);
      color_valid = 1'b0;
      chk("t3_fullpop_hit", hit, 1);
      chk("t3_fullpop_pend", pending, 7);
      chk("t3_score", score, 2);

      // Mid-game asynchronous reset
      reset_n = 1'b0;
      #1;
      chk("t5_pend", pending, 0);
      chk("t5_score", score, 0);
      chk("t5_lives", lives, 3);
      chk("t5_ovf", overflow, 0);
      chk("t5_ready", color_ready, 0);
      step();
      reset_n = 1'b1;
      do_start();

      // Test 4
      push(3'd6);
      push(3'd7);
      chk("t4_illegal", pending, 0);
      chk("t4_ready", color_ready, 1);
      chk("t4_ovf", overflow, 0);
      push(3'd3);
      chk("t4_pend1", pending, 1);
      color_valid = 1'b1; color_in = 3'd3;
      press(3'd3);
      color_valid = 1'b0;
      chk("t4_same_hit", hit, 1);
      chk("t4_same_pend", pending, 1);
      press(3'd3);
      chk("t4_hit2", hit, 1);
      chk("t4_pend0", pending, 0);
      chk("t4_sat_score", s_score, 2);

      // Test 6: saturation on 2-bit score
      for (int i = 0; i < 5; i++) push(3'(i));
      for (int i = 0; i < 5; i++) press(3'(i));
      chk("t6_main_score", score, 7);
      chk("t6_sat_score", s_score, 3);
      chk("t6_sat_hit", s_hit, 1);
      chk("t6_lives", lives, 3);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
